spw_buffer_ctrl: RTL and testbench

//  Pointer/flow-control stage wrapped around the cross-bar slot buffer (spw_buffer).

---
 rtl/spw_buffer_ctrl.sv | 86 ++++++++
 tb/tb_spw_buffer_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spw_buffer_ctrl.sv
// Pointer and flow-control stage around the cross-bar slot buffer: stores a valid/ready
// stream in FIFO order and presents it through a registered output stage.
module spw_buffer_ctrl #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  buf_wr_en_o,
    output logic [PTR_WIDTH-1:0]  buf_write_ptr_o,
    output logic [DATA_WIDTH-1:0] buf_write_data_o,
    output logic                  buf_rd_en_o,
    output logic [PTR_WIDTH-1:0]  buf_read_ptr_o,
    input  logic [DATA_WIDTH-1:0] buf_read_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [PTR_WIDTH:0]    count_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  empty;
    logic                  full_next;
    logic                  push;
    logic                  load;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        push      = in_valid_i & in_ready_q & ~flush_i;
        load      = ~empty & (~out_valid_q | out_ready_i) & ~flush_i;
        wr_ptr_d  = wr_ptr_q + {{PTR_WIDTH{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{PTR_WIDTH{1'b0}}, load};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        full_next = (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]) &&
                    (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            // Registered ready: a full buffer refuses pushes even while popping.
            in_ready_q <= ~flush_i & ~full_next;
            if (flush_i) begin
                out_valid_q <= 1'b0;
            end else if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= buf_read_data_i;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready_o       = in_ready_q;
    assign buf_wr_en_o      = push;
    assign buf_write_ptr_o  = wr_ptr_q[PTR_WIDTH-1:0];
    assign buf_write_data_o = in_data_i;
    assign buf_rd_en_o      = load;
    assign buf_read_ptr_o   = rd_ptr_q[PTR_WIDTH-1:0];
    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;
    assign count_o          = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_spw_buffer_ctrl.sv
// Self-checking bench for spw_buffer_ctrl: a directed vector table plus hand-written
// sequences for fill/drain, random back-pressure with wrap, flush and async reset.
module tb_spw_buffer_ctrl;

    localparam int PTR_WIDTH  = 3;
    localparam int DATA_WIDTH = 128;
    localparam int DEPTH      = 1 << PTR_WIDTH;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  buf_wr_en_o;
    logic [PTR_WIDTH-1:0]  buf_write_ptr_o;
    logic [DATA_WIDTH-1:0] buf_write_data_o;
    logic                  buf_rd_en_o;
    logic [PTR_WIDTH-1:0]  buf_read_ptr_o;
    logic [DATA_WIDTH-1:0] buf_read_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [PTR_WIDTH:0]    count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] mem[DEPTH];

    spw_buffer_ctrl #(.PTR_WIDTH(PTR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .buf_wr_en_o      (buf_wr_en_o),
        .buf_write_ptr_o  (buf_write_ptr_o),
        .buf_write_data_o (buf_write_data_o),
        .buf_rd_en_o      (buf_rd_en_o),
        .buf_read_ptr_o   (buf_read_ptr_o),
        .buf_read_data_i  (buf_read_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Slot buffer model: synchronous write, combinational read.
    always_ff @(posedge clk_i) begin
        if (buf_wr_en_o) mem[buf_write_ptr_o] <= buf_write_data_o;
    end
    assign buf_read_data_i = mem[buf_read_ptr_o];

    task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                         input logic [DATA_WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with scoreboard bookkeeping; inputs are set by the caller beforehand.
    task automatic cycle(output bit fired_in);
        logic [DATA_WIDTH-1:0] e;
        #1;
        fired_in = in_valid_i && in_ready_o && !flush_i;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_data_o, '1);
            end else begin
                e = exp_q.pop_front();
                check("out_order", out_data_o, e);
            end
        end
        if (fired_in) exp_q.push_back(in_data_i);
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       flush;
        logic       exp_wr_en;
        logic       exp_rd_en;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic [7:0] exp_out_data;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bit fired;
        int sent, recv, next_val, guard;
        logic [DATA_WIDTH-1:0] rvals[40];

        //               vld  data  rdy  fl   wr   rd   irdy ovld odata cnt
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd0};
        vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd1};
        vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1};
        vecs[6]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 4'd2};
        vecs[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 4'd3};
        vecs[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 4'd4};
        vecs[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 4'd0};
        vecs[10] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 4'd0};
        vecs[11] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 4'd1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 4'd0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 4'd0};

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready",  in_ready_o,  0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data",  out_data_o,  0);
        check("rst_count",     count_o,     0);
        rst_i = 1'b0;

        // Directed table: single beat, 5 beats + flush, then 0x3C first out.
        for (int i = 0; i < 14; i++) begin
            in_valid_i  = vecs[i].in_valid;
            in_data_i   = DATA_WIDTH'(vecs[i].in_data);
            out_ready_i = vecs[i].out_ready;
            flush_i     = vecs[i].flush;
            #1;
            check($sformatf("v%0d_wr_en", i), buf_wr_en_o, vecs[i].exp_wr_en);
            check($sformatf("v%0d_rd_en", i), buf_rd_en_o, vecs[i].exp_rd_en);
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_in_ready", i),  in_ready_o,  vecs[i].exp_in_ready);
            check($sformatf("v%0d_out_valid", i), out_valid_o, vecs[i].exp_out_valid);
            check($sformatf("v%0d_out_data", i),  out_data_o,  DATA_WIDTH'(vecs[i].exp_out_data));
            check($sformatf("v%0d_count", i),     count_o,     DATA_WIDTH'(vecs[i].exp_count));
        end
        flush_i = 1'b0;

        // Fill: 9 beats with the output stalled -> 8 in buffer plus the output register.
        out_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = DATA_WIDTH'(8'h10 + i);
            cycle(fired);
        end
        check("full_count",     count_o,     DEPTH);
        check("full_in_ready",  in_ready_o,  0);
        check("full_out_valid", out_valid_o, 1);
        check("full_out_data",  out_data_o,  'h10);
        in_data_i = 'h19;
        for (int i = 0; i < 2; i++) begin
            cycle(fired);
            check("held_wr_en", buf_wr_en_o, 0);
            check("held_count", count_o, DEPTH);
        end

        // Drain at one beat per cycle while the source keeps pushing.
        out_ready_i = 1'b1;
        next_val = 'h19;
        for (int i = 0; i < 12; i++) begin
            in_data_i = DATA_WIDTH'(next_val);
            cycle(fired);
            if (fired) next_val++;
            check("drain_out_valid", out_valid_o, 1);
            if (i == 0) begin
                check("drain_in_ready", in_ready_o, 1);
                check("drain_count",    count_o,    DEPTH - 1);
            end
        end
        in_valid_i = 1'b0;
        guard = 0;
        while ((out_valid_o || count_o != 0) && guard < 40) begin
            cycle(fired);
            guard++;
        end
        check("drain_timeout", guard < 40, 1);
        check("drain_left", exp_q.size(), 0);

        // Random back-pressure with 40 random beats; wraps the pointers twice.
        for (int i = 0; i < 40; i++) rvals[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; recv = 0; guard = 0;
        while ((sent < 40 || out_valid_o || count_o != 0) && guard < 600) begin
            in_valid_i  = (sent < 40);
            in_data_i   = (sent < 40) ? rvals[sent] : '0;
            out_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (out_valid_o && out_ready_i) begin
                check("rand_order", out_data_o, rvals[recv]);
                recv++;
            end
            cycle(fired);
            if (fired) sent++;
            guard++;
        end
        check("rand_received", recv, 40);
        check("rand_left", exp_q.size(), 0);

        // Async reset mid-stream.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_i = DATA_WIDTH'(8'h50 + i);
            cycle(fired);
        end
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_in_ready",  in_ready_o,  0);
        check("arst_out_valid", out_valid_o, 0);
        check("arst_out_data",  out_data_o,  0);
        check("arst_count",     count_o,     0);
        check("arst_wr_en",     buf_wr_en_o, 0);
        check("arst_rd_en",     buf_rd_en_o, 0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("post_arst_in_ready", in_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
